// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, op codes and defaults for the divide scheduler
package div_pkg;
  typedef enum logic [2:0] {IDLE, START, BUSY, DONE, DRAIN} div_state_e;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int DIV_TIMEOUT = 64;
endpackage

// File: rtl/div_special_case.sv
// div_special_case: flags divide-by-zero and signed overflow and forms their RISC-V results
module div_special_case
  import div_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [1:0]         ctrl_i,
  input  logic [D_WIDTH-1:0] num_i,
  input  logic [D_WIDTH-1:0] den_i,
  output logic               special_o,
  output logic [D_WIDTH-1:0] result_o
);
  logic den_zero, ovf, is_rem;
  always_comb begin
    den_zero  = den_i == '0;
    ovf       = (ctrl_i == OP_DIV || ctrl_i == OP_REM) && num_i == {1'b1, {(D_WIDTH-1){1'b0}}} && &den_i;
    is_rem    = ctrl_i == OP_REM || ctrl_i == OP_REMU;
    special_o = den_zero || ovf;
    result_o  = den_zero ? (is_rem ? num_i : '1) : (is_rem ? '0 : num_i);
  end
endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: sequences a multi-cycle divider from Execute, with stall, flush and watchdog
module div_scheduler
  import div_pkg::*;
#(
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = DIV_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_en_e,
  input  logic [1:0]         div_ctrl_e,
  input  logic [D_WIDTH-1:0] rd1_e,
  input  logic [D_WIDTH-1:0] rd2_e,
  input  logic               flush_e,
  input  logic               div_done,
  input  logic [D_WIDTH-1:0] div_result,
  output logic               div_start,
  output logic [1:0]         div_ctrl,
  output logic [D_WIDTH-1:0] div_num,
  output logic [D_WIDTH-1:0] div_den,
  output logic               stall_div,
  output logic [D_WIDTH-1:0] result_q,
  output logic               result_valid,
  output logic               div_err
);
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  div_state_e state_q, state_d;
  logic [WDW-1:0] wd_q;
  logic special, accept, wd_exp, busy_end, busy_keep;
  logic [D_WIDTH-1:0] special_result;
  div_special_case #(.D_WIDTH(D_WIDTH)) u_special (
    .ctrl_i   (div_ctrl_e),
    .num_i    (rd1_e),
    .den_i    (rd2_e),
    .special_o(special),
    .result_o (special_result)
  );
  assign accept       = state_q == IDLE && div_en_e && !flush_e;
  assign wd_exp       = wd_q == WD_LAST;
  assign busy_end     = div_done || wd_exp;
  assign busy_keep    = state_q == BUSY && !flush_e && busy_end;
  assign div_start    = state_q == START && !flush_e;
  assign result_valid = state_q == DONE;
  assign stall_div    = accept || state_q == START || state_q == BUSY || (state_q == DRAIN && div_en_e);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (special ? DONE : START) : IDLE;
      START:   state_d = flush_e ? IDLE : BUSY;
      BUSY:    state_d = busy_end ? (flush_e ? IDLE : DONE) : (flush_e ? DRAIN : BUSY);
      DONE:    state_d = IDLE;
      DRAIN:   state_d = busy_end ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // The watchdog runs through BUSY and DRAIN and restarts from zero on every BUSY entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wd_q     <= '0;
      result_q <= '0;
      div_err  <= 1'b0;
      div_ctrl <= '0;
      div_num  <= '0;
      div_den  <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= (state_q == BUSY || state_q == DRAIN) ? wd_q + 1'b1 : '0;
      if (accept && special) result_q <= special_result;
      else if (busy_keep) result_q <= div_done ? div_result : '0;
      if (busy_keep && !div_done) div_err <= 1'b1;
      if (accept && !special) begin
        div_ctrl <= div_ctrl_e;
        div_num  <= rd1_e;
        div_den  <= rd2_e;
      end
    end
  end
endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: directed and randomized transactions checked against a transaction-level model
module tb_div_scheduler;
  localparam int W = 32;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b1;
  logic div_en_e = 1'b0, flush_e = 1'b0, div_done = 1'b0;
  logic [1:0] div_ctrl_e = 2'b00;
  logic [W-1:0] rd1_e = '0, rd2_e = '0, div_result = '0;
  logic div_start, stall_div, result_valid, div_err;
  logic [1:0] div_ctrl;
  logic [W-1:0] div_num, div_den, result_q;
  int checks = 0, failures = 0;
  logic err_exp = 1'b0;
  div_scheduler #(.D_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .div_en_e(div_en_e), .div_ctrl_e(div_ctrl_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .flush_e(flush_e), .div_done(div_done),
    .div_result(div_result), .div_start(div_start), .div_ctrl(div_ctrl),
    .div_num(div_num), .div_den(div_den), .stall_div(stall_div),
    .result_q(result_q), .result_valid(result_valid), .div_err(div_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    if (!op[0] && a == 32'h8000_0000 && b == '1) return op[1] ? '0 : a;
    case (op)
      2'd0:    return W'($signed(a) / $signed(b));
      2'd1:    return a / b;
      2'd2:    return W'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction
  // lat = cycles from the divider's start pulse to its done pulse; 0 withholds done entirely.
  task automatic run_txn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input string tag);
    logic special, stray;
    logic [W-1:0] res, got;
    int exp_lat, starts, stalls, valids, vcyc, done_at;
    special = b == '0 || (!op[0] && a == 32'h8000_0000 && b == '1);
    res = (!special && lat == 0) ? '0 : ref_div(op, a, b);
    exp_lat = special ? 1 : (lat == 0 ? TO + 2 : lat + 2);
    starts = 0; stalls = 0; valids = 0; vcyc = -1; done_at = -1; got = 'x;
    stray = $urandom_range(0, 1) == 1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      div_en_e = vcyc < 0;
      div_ctrl_e = op; rd1_e = a; rd2_e = b;
      div_done = c == done_at || (stray && (c == 0 || vcyc >= 0));
      div_result = c == done_at ? ref_div(op, a, b) : $urandom;
      #1;
      if (div_start) begin
        starts++;
        chk({tag, " ctrl"}, W'(div_ctrl), W'(op));
        chk({tag, " num"}, div_num, a);
        chk({tag, " den"}, div_den, b);
        if (lat > 0) done_at = c + lat;
      end
      if (stall_div) stalls++;
      if (result_valid) begin
        valids++;
        if (vcyc < 0) begin vcyc = c; got = result_q; end
      end
      if (vcyc >= 0 && c >= vcyc + 2) break;
    end
    div_en_e = 1'b0; div_done = 1'b0;
    if (!special && lat == 0) err_exp = 1'b1;
    chk({tag, " starts"}, starts, special ? 0 : 1);
    chk({tag, " stalls"}, stalls, exp_lat);
    chk({tag, " latency"}, vcyc, exp_lat);
    chk({tag, " valids"}, valids, 1);
    chk({tag, " result"}, got, res);
    chk({tag, " err"}, W'(div_err), W'(err_exp));
  endtask
  task automatic run_flush();
    logic [W-1:0] a2, b2, got;
    int l2, starts, stalls, valids, vcyc, s2;
    a2 = $urandom; b2 = $urandom_range(1, 1000); l2 = $urandom_range(1, 30);
    starts = 0; stalls = 0; valids = 0; vcyc = -1; s2 = -1; got = 'x;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      flush_e = c == 7;
      div_en_e = c != 7 && vcyc < 0;
      div_ctrl_e = 2'b00;
      rd1_e = c < 8 ? 32'd1000 : a2;
      rd2_e = c < 8 ? 32'd9 : b2;
      div_done = c == 21 || (s2 >= 0 && c == s2 + l2);
      div_result = c == 21 ? 32'hDEAD_BEEF : ref_div(2'b00, a2, b2);
      #1;
      if (div_start) begin
        starts++;
        if (c > 1) begin
          s2 = c;
          chk("flush num", div_num, a2);
          chk("flush den", div_den, b2);
        end
      end
      if (stall_div && c >= 8) stalls++;
      if (result_valid) begin
        valids++;
        if (vcyc < 0) begin vcyc = c; got = result_q; end
      end
      if (vcyc >= 0 && c >= vcyc + 2) break;
    end
    flush_e = 1'b0; div_en_e = 1'b0; div_done = 1'b0;
    chk("flush starts", starts, 2);
    chk("flush restart", s2, 23);
    chk("flush latency", vcyc, 24 + l2);
    chk("flush stalls", stalls, 16 + l2);
    chk("flush valids", valids, 1);
    chk("flush result", got, ref_div(2'b00, a2, b2));
  endtask
  task automatic check_zero(input string tag);
    chk({tag, " start"}, W'(div_start), '0);
    chk({tag, " stall"}, W'(stall_div), '0);
    chk({tag, " valid"}, W'(result_valid), '0);
    chk({tag, " err"}, W'(div_err), '0);
    chk({tag, " result"}, result_q, '0);
    chk({tag, " num"}, div_num, '0);
    chk({tag, " den"}, div_den, '0);
    chk({tag, " ctrl"}, W'(div_ctrl), '0);
  endtask
  task automatic run_reset();
    int bad;
    @(negedge clk);
    div_en_e = 1'b1; div_ctrl_e = 2'b00; rd1_e = 32'd1000; rd2_e = 32'd3;
    repeat (6) @(negedge clk);
    div_en_e = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    err_exp = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rst = 1'b0;
      div_done = c == 0;
      div_result = 32'h1234_5678;
      #1;
      if (result_valid || div_start || stall_div) bad++;
    end
    div_done = 1'b0;
    chk("postrst quiet", bad, 0);
    check_zero("postrst");
  endtask
  initial begin
    logic [1:0] op;
    logic [W-1:0] a, b;
    int k;
    #12 check_zero("reset");
    @(negedge clk) rst = 1'b0;
    run_txn(2'b00, 32'd100, 32'd7, 33, "div100_7");
    run_txn(2'b11, 32'd5, 32'd0, 5, "remu5_0");
    run_txn(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5, "div_ovf");
    run_txn(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5, "rem_ovf");
    run_txn(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 3, "divu_big");
    run_flush();
    for (int i = 0; i < 25; i++) begin
      op = 2'($urandom);
      a = $urandom;
      b = $urandom;
      k = $urandom_range(0, 7);
      if (k == 0) b = '0;
      else if (k == 1) begin a = 32'h8000_0000; b = '1; end
      else if (k == 2) b = $urandom_range(1, 16);
      else if (k == 3) b = 32'd0 - $urandom_range(1, 16);
      run_txn(op, a, b, $urandom_range(1, 40), $sformatf("rand%0d", i));
    end
    run_txn(2'b00, 32'd1234, 32'd5, 0, "timeout");
    run_txn(2'b01, 32'd77, 32'd7, 9, "after_to");
    run_reset();
    run_txn(2'b10, 32'hFFFF_FFF9, 32'd2, 4, "post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
